// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame defaults and parity helper.
// Also used by the matching transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } uart_state_e;

   localparam int unsigned UART_DATA_BITS    = 8;
   localparam int unsigned UART_CLKS_PER_BIT = 16;

   // Zero-extended callers are safe: padding bits do not change even parity.
   function automatic logic even_parity(input logic [31:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx_parity_if.sv
// Received-byte output channel: valid/ready handshake with per-byte error flags.
interface uart_rx_parity_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 data_ready;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun_err;

   modport master (
      output data_out, data_valid, parity_err, frame_err, overrun_err,
      input  data_ready
   );

   modport slave (
      input  data_out, data_valid, parity_err, frame_err, overrun_err,
      output data_ready
   );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial input with falling-edge detect.
// Resets to the idle-high level so reset release alone never looks like a start bit.
module uart_rx_sync (
   input  logic clk_sis,
   input  logic rst,
   input  logic i_rx,
   output logic o_rx_s,
   output logic o_fall
);
   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk_sis or negedge rst) begin
      if (!rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_rx;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_rx_s = r_sync;
   assign o_fall = r_prev & ~r_sync;
endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver: 8E1-style frames sampled mid-bit by a baud counter, delivered through
// a valid/ready output register carrying parity, framing and overrun flags.
module uart_rx_parity
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
   input  logic             clk_sis,
   input  logic             rst,
   input  logic             rx,
   output logic             busy,
   uart_rx_parity_if.master rx_if
);
   localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int unsigned      IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   uart_state_e          r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]     r_idx, w_idx_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic                 r_perr, w_perr_nxt;
   logic                 w_rx_s;
   logic                 w_fall;
   logic                 w_stop_smp;
   logic                 w_load;

   uart_rx_sync u_sync (
      .clk_sis (clk_sis),
      .rst     (rst),
      .i_rx    (rx),
      .o_rx_s  (w_rx_s),
      .o_fall  (w_fall)
   );

   always_ff @(posedge clk_sis or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_perr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_perr  <= w_perr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_perr_nxt  = r_perr;
      w_stop_smp  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_fall) begin
               w_state_nxt = START;
               w_cnt_nxt   = '0;
            end
         end
         START: begin
            if (r_cnt == CNT_HALF) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = w_rx_s ? IDLE : DATA;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         DATA: begin
            if (r_cnt == CNT_FULL) begin
               w_cnt_nxt          = '0;
               w_shift_nxt[r_idx] = w_rx_s;
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = PARITY;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         PARITY: begin
            if (r_cnt == CNT_FULL) begin
               w_cnt_nxt   = '0;
               w_perr_nxt  = w_rx_s ^ even_parity(32'(r_shift));
               w_state_nxt = STOP;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         STOP: begin
            if (r_cnt == CNT_FULL) begin
               w_cnt_nxt   = '0;
               w_stop_smp  = 1'b1;
               // A low stop bit parks in WAIT_HIGH so a break cannot re-trigger.
               w_state_nxt = w_rx_s ? IDLE : WAIT_HIGH;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (w_rx_s) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign busy   = (r_state != IDLE);
   assign w_load = w_stop_smp & (~rx_if.data_valid | rx_if.data_ready);

   // A load in the same cycle as a transfer wins, keeping data_valid high.
   always_ff @(posedge clk_sis or negedge rst) begin
      if (!rst) begin
         rx_if.data_out    <= '0;
         rx_if.data_valid  <= 1'b0;
         rx_if.parity_err  <= 1'b0;
         rx_if.frame_err   <= 1'b0;
         rx_if.overrun_err <= 1'b0;
      end else begin
         rx_if.overrun_err <= w_stop_smp & rx_if.data_valid & ~rx_if.data_ready;
         if (w_load) begin
            rx_if.data_out   <= r_shift;
            rx_if.parity_err <= r_perr;
            rx_if.frame_err  <= ~w_rx_s;
            rx_if.data_valid <= 1'b1;
         end else if (rx_if.data_valid && rx_if.data_ready) begin
            rx_if.data_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity: table of frames plus hand-written corner sequences.
module tb_uart_rx_parity;
   import uart_pkg::*;

   localparam int CPB = 16;
   // 2 sync flops + 1 edge-detect cycle + half bit to start sample + 10 full bits to stop sample
   localparam int LATENCY = 3 + CPB / 2 + 10 * CPB;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic [7:0] exp_d;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         cyc;
   } rec_t;

   logic clk_sis = 1'b0;
   logic rst     = 1'b0;
   logic rx      = 1'b1;
   logic busy;

   uart_rx_parity_if #(.DATA_BITS(8)) u_if ();

   uart_rx_parity #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk_sis (clk_sis),
      .rst     (rst),
      .rx      (rx),
      .busy    (busy),
      .rx_if   (u_if)
   );

   always #5 clk_sis = ~clk_sis;

   int   cyc = 0;
   rec_t q[$];
   int   ov_count = 0;
   int   ov_cyc   = 0;
   int   last_start = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always @(posedge clk_sis) cyc <= cyc + 1;

   always @(negedge clk_sis) begin
      rec_t r;
      if (u_if.data_valid && u_if.data_ready) begin
         r.d   = u_if.data_out;
         r.pe  = u_if.parity_err;
         r.fe  = u_if.frame_err;
         r.cyc = cyc;
         q.push_back(r);
      end
      if (u_if.overrun_err) begin
         ov_count++;
         ov_cyc = cyc;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int tail);
      logic [10:0] bits;
      bits = {stop, par, d, 1'b0};
      @(posedge clk_sis); #1;
      rx = 1'b0;
      last_start = cyc;
      for (int k = 1; k < 11; k++) begin
         repeat (CPB) @(posedge clk_sis);
         #1;
         rx = bits[k];
      end
      repeat (CPB) @(posedge clk_sis);
      repeat (tail) @(posedge clk_sis);
      #1;
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_sis);
      #1;
   endtask

   vec_t vecs[6];

   initial begin
      int n;
      int s2;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
      vecs[5] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1};

      u_if.data_ready = 1'b1;
      idle(3);
      check("rst_data_out",   u_if.data_out,    0);
      check("rst_valid",      u_if.data_valid,  0);
      check("rst_parity_err", u_if.parity_err,  0);
      check("rst_frame_err",  u_if.frame_err,   0);
      check("rst_overrun",    u_if.overrun_err, 0);
      check("rst_busy",       busy,             0);
      rst = 1'b1;
      idle(10);

      for (int i = 0; i < 6; i++) begin
         q.delete();
         send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 0);
         idle(20);
         check($sformatf("vec%0d_count", i), q.size(), 1);
         if (q.size() > 0) begin
            check($sformatf("vec%0d_data", i),    q[0].d,  vecs[i].exp_d);
            check($sformatf("vec%0d_perr", i),    q[0].pe, vecs[i].exp_pe);
            check($sformatf("vec%0d_ferr", i),    q[0].fe, vecs[i].exp_fe);
            check($sformatf("vec%0d_latency", i), q[0].cyc - last_start, LATENCY);
         end
      end

      // Short low glitch: start-bit check rejects it.
      q.delete();
      ov_count = 0;
      @(posedge clk_sis); #1;
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      check("glitch_busy_hi", busy, 1);
      n = 0;
      while (busy && n < 10) begin
         idle(1);
         n++;
      end
      check("glitch_busy_drop", busy, 0);
      idle(40);
      check("glitch_no_byte", q.size(), 0);
      check("glitch_no_ovr",  ov_count, 0);
      check("glitch_idle",    busy,     0);

      // Low stop bit followed by a long low line.
      q.delete();
      fork
         send_frame(8'h3C, 1'b0, 1'b0, 60);
         begin
            idle(230);
            check("brk_busy_held", busy, 1);
         end
      join
      idle(5);
      check("brk_busy_drop", busy, 0);
      idle(100);
      check("brk_count", q.size(), 1);
      if (q.size() > 0) begin
         check("brk_data", q[0].d,  8'h3C);
         check("brk_ferr", q[0].fe, 1);
         check("brk_perr", q[0].pe, 0);
      end

      // Overrun with the consumer stalled.
      q.delete();
      ov_count = 0;
      u_if.data_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1, 0);
      send_frame(8'h22, 1'b0, 1'b1, 0);
      s2 = last_start;
      idle(5);
      check("ovr_pulses",  ov_count,        1);
      check("ovr_timing",  ov_cyc - s2,     LATENCY);
      check("ovr_valid",   u_if.data_valid, 1);
      check("ovr_held",    u_if.data_out,   8'h11);
      check("ovr_no_xfer", q.size(),        0);
      u_if.data_ready = 1'b1;
      idle(1);
      check("ovr_valid_drop", u_if.data_valid, 0);
      check("ovr_xfer_count", q.size(), 1);
      if (q.size() > 0) check("ovr_xfer_data", q[0].d, 8'h11);

      // Reset during data bit 4 of 0xFF.
      q.delete();
      @(posedge clk_sis); #1;
      rx = 1'b0;
      idle(CPB);
      rx = 1'b1;
      idle(4 * CPB + CPB / 2);
      check("mid_busy", busy, 1);
      rst = 1'b0;
      #1;
      check("mid_rst_busy",  busy,            0);
      check("mid_rst_valid", u_if.data_valid, 0);
      check("mid_rst_data",  u_if.data_out,   0);
      idle(3);
      rst = 1'b1;
      idle(40);
      check("mid_idle",     busy,     0);
      check("mid_no_byte",  q.size(), 0);
      send_frame(8'h5A, 1'b0, 1'b1, 0);
      idle(20);
      check("post_count", q.size(), 1);
      if (q.size() > 0) begin
         check("post_data", q[0].d,  8'h5A);
         check("post_perr", q[0].pe, 0);
         check("post_ferr", q[0].fe, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_parity.md
Name: uart_rx_parity

Overview:
- Serial receiver paired with the UART transmitter; consumes the tx1 line of the peer UART.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of data), 1 stop bit (1); line idles high.
- Samples the line with a baud counter in the system clock domain.
- Delivers each byte through a valid/ready output register with parity, framing and overrun error flags.

Parameters:
- CLKS_PER_BIT, 16, clk_sis cycles per serial bit; must be even and ≥ 4.
- DATA_BITS, 8, data bits per frame; the output width follows it.

Ports:
- clk_sis  in  1  system clock; the only clock.
- rst  in  1  asynchronous reset, active-low; all registers take reset values immediately while low.
- rx  in  1  serial line from the peer tx1; asynchronous to clk_sis.
- data_ready  in  1  consumer can accept the byte this cycle.
- data_out  out  DATA_BITS  received byte.
- data_valid  out  1  data_out and its error flags are valid.
- parity_err  out  1  parity mismatch for the presented byte; qualified by data_valid.
- frame_err  out  1  stop bit sampled 0 for the presented byte; qualified by data_valid.
- overrun_err  out  1  one-cycle pulse: a completed frame was dropped.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - data_out = 0; data_valid, parity_err, frame_err, overrun_err = 0; busy = 0.
  - State = IDLE; synchroniser flops = 1.
- Synchroniser: rx passes through two flops to give rx_s. All decisions use rx_s; its previous value is kept for falling-edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. A baud counter (clog2(CLKS_PER_BIT) bits) and a bit index (0..DATA_BITS-1) run under it.
- IDLE:
  - On a 1→0 transition of rx_s, go to START with baud counter = 0.
- START:
  - Sample at count CLKS_PER_BIT/2-1 (mid-bit).
  - rx_s = 1 means a glitch: return to IDLE, no output, no flag.
  - rx_s = 0: reset the counter and go to DATA with bit index = 0.
- DATA:
  - Sample at count CLKS_PER_BIT-1 (one full bit later, i.e. mid-bit); the counter wraps to 0 on each sample.
  - Shift rx_s into shift[bit_index] (LSB first).
  - After bit DATA_BITS-1, go to PARITY.
- PARITY:
  - Sample after CLKS_PER_BIT cycles.
  - Store perr = rx_s XOR (^shift).
  - Go to STOP.
- STOP:
  - Sample after CLKS_PER_BIT cycles; ferr = ~rx_s.
  - Load the output register on this sample cycle (see below).
  - rx_s = 1: go to IDLE.
  - rx_s = 0: go to WAIT_HIGH. This prevents a break or low line from re-triggering.
- WAIT_HIGH: stay until rx_s = 1, then go to IDLE. No samples are taken.
- Output register:
  - Load condition: STOP sample cycle AND (data_valid = 0 OR data_ready = 1).
  - On load, data_out, parity_err and frame_err update together and data_valid = 1 on the next edge. Latency from the stop-bit sample to data_valid is 1 cycle.
  - Handshake: a transfer occurs when data_valid AND data_ready are both high. data_valid then drops on the next edge unless a load happens in the same cycle.
  - Simultaneous transfer and load: the load wins, data_valid stays 1 and the new byte is presented.
  - If data_valid = 1 and data_ready = 0 at the STOP sample: the new byte is discarded, the held byte stays unchanged, and overrun_err pulses for exactly one cycle.
  - data_out and the flags hold stable while data_valid = 1 and data_ready = 0.
- A parity or frame error never suppresses the byte; it is always delivered with its flags.
- Reset asserted mid-frame: the frame is lost, no partial byte is presented, and all outputs go to reset values. After release the block waits in IDLE for a fresh falling edge.
- A line held low through reset release does not start a frame, because the synchroniser resets to 1 and a 1→0 edge is required.

Decomposition:
- Shared package uart_pkg:
  - state encoding: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH;
  - UART_DATA_BITS = 8;
  - default CLKS_PER_BIT;
  - a function for even parity.
- The transmitter adopts the same package.
- One sub-module: uart_rx_sync. It holds the two-flop synchroniser plus falling-edge detect, reset to 1, and is reusable by other serial inputs.
- Baud counter and FSM stay in the top level.

Test Plan (CLKS_PER_BIT = 16, data_ready = 1 unless stated):
- Frame 0xA5 with parity 0 and stop 1 → one data_valid pulse, data_out = 0xA5, parity_err = 0, frame_err = 0, data_valid at the stop mid-sample + 1 cycle.
- Frame 0x01 with parity bit sent as 0 → data_out = 0x01, parity_err = 1, frame_err = 0.
- rx low for 4 cycles then high → no data_valid, no flag, busy drops back to 0 within 8 + 2 cycles.
- Frame 0x3C with stop bit 0, then rx held low for 60 cycles, then high → one byte 0x3C with frame_err = 1, no second frame, busy stays 1 until rx_s = 1.
- data_ready = 0, send 0x11 then 0x22 back-to-back → data_out stays 0x11, overrun_err pulses once at the second stop sample. Raise data_ready → 0x11 transfers and data_valid drops.
- Reset asserted during DATA bit 4 of frame 0xFF, released, then frame 0x5A sent → nothing presented for 0xFF; 0x5A received cleanly.
